ac_sequencer: RTL and testbench

- Micro-sequencer that drives the accumulator's control strobes: write from bus, increment, clear, ALU-to-AC and AC-to-R.
- Sits between the instruction decoder and the AC/ALU datapath.
- Accepts one command at a time over a valid/ready handshake and expands it into correctly ordered, mutually exclusive single-cycle strobes.
- Handles multi-cycle waits on the bus and the ALU.

---
 rtl/ac_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_ac_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_sequencer.sv
// ---------------------------------------------------------------------------
// ac_sequencer
//
// Micro-sequencer between the instruction decoder and the AC/ALU datapath.
// It takes one command at a time and expands it into ordered, mutually
// exclusive single-cycle strobes. It also covers the multi-cycle waits on
// the bus (LOAD) and on the ALU.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. While the
// sequencer is busy, cmd_valid is ignored and the decoder keeps the command
// stable until it is accepted. cmd_op and cmd_cnt are sampled only on the
// accepting edge.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid/ready command handshake
//   cmd_op          0 NOP, 1 CLR, 2 INC, 3 LOAD, 4 ALU, 5 STR, 6-7 illegal
//   cmd_cnt         INC repeat count (CNT_W bits)
//   bus_valid       bus data valid, used by LOAD
//   alu_done        ALU result valid
//   alu_start       one-cycle ALU launch pulse
//   ac_write_en     AC loads from bus
//   ac_inc_en       AC increments
//   ac_clr_en       AC clears
//   ac_alu_to_ac    AC loads ALU result
//   ac_to_r         R loads from bus
//   done / err      command-complete pulse / error flag, raised together
//   busy            high whenever the FSM is not IDLE
//   perf_cmd_count  completed-command counter (tied to 0 unless enabled)
//   state_dbg       current FSM state encoding
//
// Optional feature: define AC_SEQ_PERF_EN to build the 16-bit completed
// command counter. It counts every done pulse, errored commands included.
//
// Every output comes straight from a flop. Each flop is updated on the same
// edge as the state transition that causes it.
// ---------------------------------------------------------------------------
module ac_sequencer #(
  parameter int CNT_W       = 8,
  parameter int BUS_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             bus_valid,
  input  logic             alu_done,
  output logic             alu_start,
  output logic             ac_write_en,
  output logic             ac_inc_en,
  output logic             ac_clr_en,
  output logic             ac_alu_to_ac,
  output logic             ac_to_r,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [15:0]      perf_cmd_count,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ALU  = 3'd4;
  localparam logic [2:0] OP_STR  = 3'd5;

  localparam int              WAIT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_INC      = 3'd2,
    S_WAIT_BUS = 3'd3,
    S_ALU_GO   = 3'd4,
    S_ALU_WAIT = 3'd5,
    S_STR      = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt_q;   // INC pulses still to issue, including the current one
  logic [WAIT_W-1:0]  wait_q;  // WAIT_BUS cycles already spent without bus_valid
  logic               pend_q;  // DONE's first cycle is the command's tail; done comes next
  logic               err_q;   // error to report with the deferred done

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      alu_start    <= 1'b0;
      ac_write_en  <= 1'b0;
      ac_inc_en    <= 1'b0;
      ac_clr_en    <= 1'b0;
      ac_alu_to_ac <= 1'b0;
      ac_to_r      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // Strobes and completion flags are single-cycle unless re-asserted below.
      alu_start    <= 1'b0;
      ac_write_en  <= 1'b0;
      ac_inc_en    <= 1'b0;
      ac_clr_en    <= 1'b0;
      ac_alu_to_ac <= 1'b0;
      ac_to_r      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            case (cmd_op)
              OP_NOP: begin
                // No strobe to issue. The extra DONE cycle keeps the latency
                // equal to a single-strobe command.
                state  <= S_DONE;
                pend_q <= 1'b1;
              end
              OP_CLR: begin
                state     <= S_CLR;
                ac_clr_en <= 1'b1;
              end
              OP_INC: begin
                if (cmd_cnt != '0) begin
                  state     <= S_INC;
                  cnt_q     <= cmd_cnt;
                  ac_inc_en <= 1'b1;
                end else begin
                  state  <= S_DONE;
                  pend_q <= 1'b1;
                end
              end
              OP_LOAD: begin
                state  <= S_WAIT_BUS;
                wait_q <= '0;
              end
              OP_ALU: begin
                state     <= S_ALU_GO;
                alu_start <= 1'b1;
              end
              OP_STR: begin
                state   <= S_STR;
                ac_to_r <= 1'b1;
              end
              default: begin
                state  <= S_DONE;
                pend_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end

        S_CLR, S_STR: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_INC: begin
          // cnt_q == 1 means the pulse now on the output is the last one.
          if (cnt_q > CNT_W'(1)) begin
            cnt_q     <= cnt_q - CNT_W'(1);
            ac_inc_en <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_WAIT_BUS: begin
          // bus_valid is tested before the timeout, so a bus_valid in the
          // last permitted cycle still counts as a successful load.
          if (bus_valid) begin
            ac_write_en <= 1'b1;
            state       <= S_DONE;
            pend_q      <= 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        S_ALU_GO: begin
          // alu_done is not sampled here, so a done in the launch cycle is ignored.
          state <= S_ALU_WAIT;
        end

        S_ALU_WAIT: begin
          if (alu_done) begin
            ac_alu_to_ac <= 1'b1;
            state        <= S_DONE;
            pend_q       <= 1'b1;
          end
        end

        S_DONE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            done   <= 1'b1;
            err    <= err_q;
          end else begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef AC_SEQ_PERF_EN
  logic [15:0] perf_q;

  // Counts every done pulse and wraps from 16'hFFFF to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= 16'd0;
    end else if (done) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cmd_count = perf_q;
`else
  assign perf_cmd_count = 16'd0;
`endif

endmodule

// File: tb/tb_ac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ac_sequencer
//
// Directed bench for ac_sequencer with the default parameters
// (CNT_W=8, BUS_TIMEOUT=16).
//
// Inputs change 1 ns after the rising edge. Outputs are observed at the
// same point, so each observation shows the flops updated by the previous
// edge. Cycle T+n means the n-th cycle after the accepting edge T.
// ---------------------------------------------------------------------------
module tb_ac_sequencer;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ALU  = 3'd4;
  localparam logic [2:0] OP_STR  = 3'd5;

  // obs = {alu_start, ac_write_en, ac_inc_en, ac_clr_en, ac_alu_to_ac,
  //        ac_to_r, done, err, busy, cmd_ready}
  localparam logic [9:0] O_IDLE   = 10'b00_0000_0001;
  localparam logic [9:0] O_BUSY   = 10'b00_0000_0010;
  localparam logic [9:0] O_DONE   = 10'b00_0000_1010;
  localparam logic [9:0] O_DERR   = 10'b00_0000_1110;
  localparam logic [9:0] O_CLR    = 10'b00_0100_0010;
  localparam logic [9:0] O_INC    = 10'b00_1000_0010;
  localparam logic [9:0] O_WR     = 10'b01_0000_0010;
  localparam logic [9:0] O_ASTART = 10'b10_0000_0010;
  localparam logic [9:0] O_A2A    = 10'b00_0010_0010;
  localparam logic [9:0] O_TOR    = 10'b00_0001_0010;

`ifdef AC_SEQ_PERF_EN
  localparam logic [15:0] EXP_PERF = 16'd3;
`else
  localparam logic [15:0] EXP_PERF = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_cnt;
  logic        bus_valid;
  logic        alu_done;
  logic        alu_start;
  logic        ac_write_en;
  logic        ac_inc_en;
  logic        ac_clr_en;
  logic        ac_alu_to_ac;
  logic        ac_to_r;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] perf_cmd_count;
  logic [2:0]  state_dbg;
  logic [9:0]  obs;

  int vectors     = 0;
  int miscompares = 0;

  assign obs = {alu_start, ac_write_en, ac_inc_en, ac_clr_en, ac_alu_to_ac,
                ac_to_r, done, err, busy, cmd_ready};

  ac_sequencer #(.CNT_W(8), .BUS_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_cnt        (cmd_cnt),
    .bus_valid      (bus_valid),
    .alu_done       (alu_done),
    .alu_start      (alu_start),
    .ac_write_en    (ac_write_en),
    .ac_inc_en      (ac_inc_en),
    .ac_clr_en      (ac_clr_en),
    .ac_alu_to_ac   (ac_alu_to_ac),
    .ac_to_r        (ac_to_r),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .perf_cmd_count (perf_cmd_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call from an IDLE cycle. Returns in cycle T+1 with cmd_valid dropped.
  task automatic issue(input logic [2:0] op, input logic [7:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_cnt   = 8'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 8'd0;
    bus_valid = 1'b0; alu_done = 1'b0;
    tick(); tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++; $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE);
    end
    vectors++;
    if (perf_cmd_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_perf: got %0d expected 0", perf_cmd_count);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++; $display("FAIL reset_release: got %b expected %b", obs, O_IDLE);
    end
  endtask

  task automatic test_single_strobe(input logic [2:0] op, input logic [9:0] strobe);
    logic [9:0] exp_seq [3];
    exp_seq = '{strobe, O_DONE, O_IDLE};
    issue(op, 8'd0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL single op%0d T+%0d: got %b expected %b", op, i + 1, obs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_zero_work(input logic [2:0] op, input logic [7:0] cnt, input logic [9:0] done_vec);
    logic [9:0] exp_seq [3];
    exp_seq = '{O_BUSY, done_vec, O_IDLE};
    issue(op, cnt);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL zero_work op%0d T+%0d: got %b expected %b", op, i + 1, obs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_inc5();
    logic [9:0] exp_v;
    issue(OP_INC, 8'd5);
    for (int i = 0; i < 7; i++) begin
      exp_v = (i < 5) ? O_INC : ((i == 5) ? O_DONE : O_IDLE);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL inc5 T+%0d: got %b expected %b", i + 1, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_inc255();
    int pulses  = 0;
    int done_at = 0;
    bit other   = 1'b0;
    issue(OP_INC, 8'hFF);
    for (int i = 0; i < 300 && done_at == 0; i++) begin
      if (ac_inc_en) pulses++;
      if (done) done_at = i + 1;
      if (alu_start | ac_write_en | ac_clr_en | ac_alu_to_ac | ac_to_r | err) other = 1'b1;
      tick();
    end
    vectors++;
    if (pulses != 255) begin
      miscompares++; $display("FAIL inc255_pulses: got %0d expected 255", pulses);
    end
    vectors++;
    if (done_at != 256) begin
      miscompares++; $display("FAIL inc255_done_cycle: got T+%0d expected T+256", done_at);
    end
    vectors++;
    if (other !== 1'b0) begin
      miscompares++; $display("FAIL inc255_other_strobe: got %b expected 0", other);
    end
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++; $display("FAIL inc255_idle: got %b expected %b", obs, O_IDLE);
    end
  endtask

  // bus_valid is driven high only in cycle T+bv_cycle.
  task automatic test_load(input int bv_cycle);
    logic [9:0] exp_v;
    issue(OP_LOAD, 8'd0);
    for (int i = 1; i <= bv_cycle + 3; i++) begin
      exp_v = (i <= bv_cycle) ? O_BUSY :
              (i == bv_cycle + 1) ? O_WR :
              (i == bv_cycle + 2) ? O_DONE : O_IDLE;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL load_bv%0d T+%0d: got %b expected %b", bv_cycle, i, obs, exp_v);
      end
      bus_valid = (i == bv_cycle);
      tick();
    end
    bus_valid = 1'b0;
  endtask

  task automatic test_load_timeout();
    logic [9:0] exp_v;
    issue(OP_LOAD, 8'd0);
    for (int i = 1; i <= 18; i++) begin
      exp_v = (i <= 16) ? O_BUSY : ((i == 17) ? O_DERR : O_IDLE);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL load_timeout T+%0d: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_alu();
    logic [9:0] exp_v;
    issue(OP_ALU, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      exp_v = (i == 1) ? O_ASTART :
              (i <= 5) ? O_BUSY :
              (i == 6) ? O_A2A :
              (i == 7) ? O_DONE : O_IDLE;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL alu T+%0d: got %b expected %b", i, obs, exp_v);
      end
      // The pulse in T+1 (launch cycle) must be ignored. The pulse in T+5 completes the op.
      alu_done = (i == 1) || (i == 5);
      tick();
    end
    alu_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_seq [6];
    exp_seq = '{O_CLR, O_DONE, O_IDLE, O_TOR, O_DONE, O_IDLE};
    cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_cnt = 8'd0;
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== exp_seq[i]) begin
        miscompares++; $display("FAIL back_to_back T+%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
      end
      if (i == 0) cmd_op = OP_STR;     // a new command, still offered while the sequencer is busy
      if (i == 3) cmd_valid = 1'b0;    // STR was accepted at the end of T+3
      tick();
    end
    cmd_op = 3'd0;
  endtask

  task automatic test_reset_mid_inc();
    issue(OP_INC, 8'd10);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== O_INC) begin
        miscompares++; $display("FAIL rst_mid_pulse%0d: got %b expected %b", i + 1, obs, O_INC);
      end
      if (i < 2) tick();
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++; $display("FAIL rst_mid_async: got %b expected %b", obs, O_IDLE);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== O_IDLE) begin
        miscompares++; $display("FAIL rst_mid_after%0d: got %b expected %b", i, obs, O_IDLE);
      end
      tick();
    end
  endtask

  task automatic test_perf();
    issue(OP_CLR, 8'd0);  tick(); tick();
    issue(OP_NOP, 8'd0);  tick(); tick();
    issue(3'd7, 8'd0);    tick(); tick();
    vectors++;
    if (perf_cmd_count !== EXP_PERF) begin
      miscompares++; $display("FAIL perf_count: got %0d expected %0d", perf_cmd_count, EXP_PERF);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_strobe(OP_CLR, O_CLR);
    test_single_strobe(OP_STR, O_TOR);
    test_zero_work(OP_NOP, 8'd0, O_DONE);
    test_zero_work(OP_INC, 8'd0, O_DONE);
    test_zero_work(3'd6, 8'd0, O_DERR);
    test_zero_work(3'd7, 8'd0, O_DERR);
    test_inc5();
    test_inc255();
    test_load(3);
    test_load(16);
    test_load_timeout();
    test_alu();
    test_back_to_back();
    test_reset_mid_inc();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
